// File: rtl/sigma_btn_pkg.sv
// Shared types and constants for the sigma push-button debounce / interrupt block.
package sigma_btn_pkg;

    typedef enum logic [1:0] {
        LO,
        WAIT_HI,
        HI,
        WAIT_LO
    } btn_state_t;

    localparam int unsigned PRESS_CNT_W = 16;

    // The debounced level stays high until a release has been fully qualified.
    function automatic logic level_of(btn_state_t s);
        return (s == HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/sigma_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; only the second stage is consumed.
module sigma_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d_i;
            r_s2 <= r_s1;
        end
    end

    assign q_o = r_s2;

endmodule

// File: rtl/sigma_btn_irq_ctrl.sv
// Push-button debouncer and interrupt controller: qualifies level changes with a stable-count
// FSM, raises a held interrupt per accepted press and tracks presses lost to a pending IRQ.
module sigma_btn_irq_ctrl
    import sigma_btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   btn_i,
    input  logic                   irq_ack_i,
    input  logic                   ovf_clr_i,
    output logic                   irq_o,
    output logic                   btn_level_o,
    output logic [PRESS_CNT_W-1:0] press_cnt_o,
    output logic                   overflow_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                   w_btn_sync;
    btn_state_t             r_state;
    btn_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_rise;
    logic                   r_pending;
    logic                   w_pending_nxt;
    logic                   r_overflow;
    logic                   w_overflow_nxt;
    logic                   r_btn_level;
    logic [PRESS_CNT_W-1:0] r_press_cnt;
    logic [PRESS_CNT_W-1:0] w_press_cnt_nxt;

    sigma_sync2 #(
        .W(1)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (btn_i),
        .q_o  (w_btn_sync)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise      = 1'b0;
        unique case (r_state)
            LO: begin
                if (w_btn_sync) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!w_btn_sync) begin
                    w_state_nxt = LO;
                end else if (r_cnt == CntLast) begin
                    w_state_nxt = HI;
                    w_rise      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (!w_btn_sync) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (w_btn_sync) begin
                    w_state_nxt = HI;
                end else if (r_cnt == CntLast) begin
                    w_state_nxt = LO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = LO;
            end
        endcase
    end

    // A rise coinciding with an ack re-arms the interrupt and is not counted as lost.
    always_comb begin
        w_pending_nxt   = w_rise | (r_pending & ~irq_ack_i);
        w_overflow_nxt  = (w_rise & r_pending & ~irq_ack_i) | (r_overflow & ~ovf_clr_i);
        w_press_cnt_nxt = r_press_cnt;
        if (w_rise) begin
            w_press_cnt_nxt = r_press_cnt + PRESS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= LO;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_overflow  <= 1'b0;
            r_btn_level <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_overflow  <= w_overflow_nxt;
            r_btn_level <= level_of(w_state_nxt);
            r_press_cnt <= w_press_cnt_nxt;
        end
    end

    assign irq_o       = r_pending;
    assign btn_level_o = r_btn_level;
    assign press_cnt_o = r_press_cnt;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_sigma_btn_irq_ctrl.sv
// Table-driven bench for sigma_btn_irq_ctrl with DEBOUNCE_CYCLES=4 plus a counter-wrap sequence.
module tb_sigma_btn_irq_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        btn_i;
    logic        irq_ack_i;
    logic        ovf_clr_i;
    logic        irq_o;
    logic        btn_level_o;
    logic [15:0] press_cnt_o;
    logic        overflow_o;

    int n_total;
    int n_bad;

    typedef struct {
        logic        rst;
        logic        btn;
        logic        ack;
        logic        clr;
        logic        irq;
        logic        lvl;
        logic [15:0] cnt;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    sigma_btn_irq_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .btn_i      (btn_i),
        .irq_ack_i  (irq_ack_i),
        .ovf_clr_i  (ovf_clr_i),
        .irq_o      (irq_o),
        .btn_level_o(btn_level_o),
        .press_cnt_o(press_cnt_o),
        .overflow_o (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic add(input int n, input logic rst, input logic btn, input logic ack,
                       input logic clr, input logic irq, input logic lvl, input int cnt,
                       input logic ovf);
        vec_t v;
        v.rst = rst;
        v.btn = btn;
        v.ack = ack;
        v.clr = clr;
        v.irq = irq;
        v.lvl = lvl;
        v.cnt = 16'(cnt);
        v.ovf = ovf;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Edges 0..20 of a press / release / second press, stopping one edge before the second rise.
    task automatic add_two_press_prefix();
        add(6, 0, 1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 1, 1, 1, 0);
        add(6, 0, 0, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0);
        add(6, 0, 1, 0, 0, 1, 0, 1, 0);
    endtask

    task automatic step(input logic rst, input logic btn, input logic ack, input logic clr);
        rst_i     = rst;
        btn_i     = btn;
        irq_ack_i = ack;
        ovf_clr_i = clr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic irq, input logic lvl,
                         input logic [15:0] cnt, input logic ovf);
        n_total++;
        if (irq_o !== irq || btn_level_o !== lvl || press_cnt_o !== cnt || overflow_o !== ovf)
        begin
            n_bad++;
            $display("FAIL %s: got irq=%0b lvl=%0b cnt=%04h ovf=%0b, want irq=%0b lvl=%0b cnt=%04h ovf=%0b",
                     name, irq_o, btn_level_o, press_cnt_o, overflow_o, irq, lvl, cnt, ovf);
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_i     = 1'b1;
        btn_i     = 1'b0;
        irq_ack_i = 1'b0;
        ovf_clr_i = 1'b0;

        // Reset, then clean press, release, lost second press, ack, overflow clear.
        add(2, 1, 0, 0, 0, 0, 0, 0, 0);
        add_two_press_prefix();
        add(1, 0, 1, 0, 0, 1, 1, 2, 1);
        add(1, 0, 1, 1, 0, 0, 1, 2, 1);
        add(1, 0, 1, 0, 1, 0, 1, 2, 0);
        add(1, 0, 1, 1, 0, 0, 1, 2, 0);
        add(1, 0, 1, 0, 0, 0, 1, 2, 0);

        // Bounce: 3 high, 1 low, 2 high, low; then a 10-cycle hold gives one press.
        add(2, 1, 0, 0, 0, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4, 0, 0, 0, 0, 0, 0, 0, 0);
        add(6, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4, 0, 1, 0, 0, 1, 1, 1, 0);
        add(2, 0, 0, 0, 0, 1, 1, 1, 0);

        // Ack aligned with the second rise: irq held, no overflow.
        add(2, 1, 0, 0, 0, 0, 0, 0, 0);
        add_two_press_prefix();
        add(1, 0, 1, 1, 0, 1, 1, 2, 0);
        add(1, 0, 1, 0, 0, 1, 1, 2, 0);
        add(1, 0, 1, 1, 0, 0, 1, 2, 0);

        // Overflow clear aligned with overflow set, then reset inside WAIT_HI and re-qualify.
        add(2, 1, 0, 0, 0, 0, 0, 0, 0);
        add_two_press_prefix();
        add(1, 0, 1, 0, 1, 1, 1, 2, 1);
        add(1, 0, 1, 0, 0, 1, 1, 2, 1);
        add(6, 0, 0, 0, 0, 1, 1, 2, 1);
        add(1, 0, 0, 0, 0, 1, 0, 2, 1);
        add(4, 0, 1, 0, 0, 1, 0, 2, 1);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(6, 0, 1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 1, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].btn, vecs[i].ack, vecs[i].clr);
            check($sformatf("row%0d", i), vecs[i].irq, vecs[i].lvl, vecs[i].cnt, vecs[i].ovf);
        end

        // Counter wrap: preload 0xFFFF while held, release, press again.
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        check("wrap_first_press", 1, 1, 16'h0001, 0);
        force dut.r_press_cnt = 16'hFFFF;
        step(0, 1, 0, 0);
        release dut.r_press_cnt;
        step(0, 1, 0, 0);
        check("wrap_preload", 1, 1, 16'hFFFF, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        check("wrap_released", 1, 0, 16'hFFFF, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        check("wrap_before_rise", 1, 0, 16'hFFFF, 0);
        step(0, 1, 0, 0);
        check("wrap_to_zero", 1, 1, 16'h0000, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
